// File: rtl/disp_axi_pkg.sv
// disp_axi_pkg: shared arbiter state encoding and fixed AXI read-burst attributes
package disp_axi_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ADDR = 2'b01, S_DATA = 2'b10} state_t;
  localparam logic [7:0] AXI_ARLEN_16   = 8'd15;
  localparam logic [2:0] AXI_ARSIZE_8B  = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
endpackage

// File: rtl/disp_vrdarb_sel.sv
// disp_vrdarb_sel: fixed-priority grant decision with an M1 starvation guard
module disp_vrdarb_sel
  import disp_axi_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       arb,
  output logic       pick,
  output logic       grant,
  output logic [3:0] starve
);
  logic       grant_d, grant_q;
  logic [3:0] starve_d, starve_q;
  always_comb begin
    pick     = m1_req & (~m0_req | (starve_q == 4'(STARVE_MAX)));
    grant_d  = arb ? pick : grant_q;
    // counts M0 wins that M1 had to sit through; any other outcome resets it
    starve_d = !arb ? starve_q :
               (pick | ~m1_req) ? 4'd0 :
               (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
    grant    = grant_q;
    starve   = starve_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      grant_q  <= grant_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: rtl/disp_vrdarb.sv
// disp_vrdarb: two-master AXI read-channel arbiter, one outstanding burst at a time
module disp_vrdarb
  import disp_axi_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int DW         = 64
) (
  input  logic          ACLK,
  input  logic          ARST,
  input  logic [31:0]   M0_ARADDR,
  input  logic          M0_ARVALID,
  output logic          M0_ARREADY,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RVALID,
  output logic          M0_RLAST,
  input  logic          M0_RREADY,
  input  logic [31:0]   M1_ARADDR,
  input  logic          M1_ARVALID,
  output logic          M1_ARREADY,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RVALID,
  output logic          M1_RLAST,
  input  logic          M1_RREADY,
  output logic [31:0]   ARADDR,
  output logic [7:0]    ARLEN,
  output logic [2:0]    ARSIZE,
  output logic [1:0]    ARBURST,
  output logic          ARVALID,
  input  logic          ARREADY,
  input  logic [DW-1:0] RDATA,
  input  logic          RVALID,
  input  logic          RLAST,
  output logic          RREADY,
  output logic          GRANT,
  output logic          BUSY
);
  state_t      state_d, state_q;
  logic [31:0] araddr_d, araddr_q;
  logic        arb, pick, grant, in_data;
  logic [3:0]  starve;
  disp_vrdarb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk    (ACLK),
    .rst    (ARST),
    .m0_req (M0_ARVALID),
    .m1_req (M1_ARVALID),
    .arb    (arb),
    .pick   (pick),
    .grant  (grant),
    .starve (starve)
  );
  always_comb begin
    in_data    = state_q == S_DATA;
    ARVALID    = state_q == S_ADDR;
    ARADDR     = araddr_q;
    ARLEN      = AXI_ARLEN_16;
    ARSIZE     = AXI_ARSIZE_8B;
    ARBURST    = AXI_BURST_INCR;
    BUSY       = state_q != S_IDLE;
    GRANT      = grant;
    M0_ARREADY = ARVALID & ~grant & ARREADY;
    M1_ARREADY = ARVALID & grant & ARREADY;
    RREADY     = in_data & (grant ? M1_RREADY : M0_RREADY);
    M0_RVALID  = in_data & ~grant & RVALID;
    M1_RVALID  = in_data & grant & RVALID;
    M0_RLAST   = in_data & ~grant & RLAST;
    M1_RLAST   = in_data & grant & RLAST;
    M0_RDATA   = RDATA;
    M1_RDATA   = RDATA;
  end
  always_comb begin
    arb      = (state_q == S_IDLE) & (M0_ARVALID | M1_ARVALID);
    araddr_d = arb ? (pick ? M1_ARADDR : M0_ARADDR) : araddr_q;
    state_d  = state_q == S_IDLE ? (arb ? S_ADDR : S_IDLE) :
               state_q == S_ADDR ? (ARREADY ? S_DATA : S_ADDR) :
               state_q == S_DATA ? ((RVALID & RREADY & RLAST) ? S_IDLE : S_DATA) : S_IDLE;
  end
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q  <= S_IDLE;
      araddr_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
    end
  end
endmodule

// File: doc/disp_vrdarb.md
Name: disp_vrdarb

Overview:
- Arbitrates the single AXI read channel to VRAM between two requesters: M0 (display VRAM read controller, real-time) and M1 (drawing/capture engine).
- Allows one outstanding burst at a time; owner holds the channel from grant until its RLAST beat.
- Fixed M0 priority, with a starvation guard for M1; sits between the requesters and the AXI interconnect slave port.

Parameters:
- STARVE_MAX, 4, consecutive M0 grants, while M1 is waiting, after which M1 is forced the next grant (1..15).
- DW, 64, read-data width in bits.

Ports:
- ACLK  in  1  system clock; single clock domain.
- ARST  in  1  synchronous, active-high reset.
- M0_ARADDR  in  32  M0 burst start address; held stable while M0_ARVALID is high.
- M0_ARVALID  in  1  M0 address request.
- M0_ARREADY  out  1  M0 address accepted.
- M0_RDATA  out  DW  read data (broadcast).
- M0_RVALID  out  1  data valid to M0.
- M0_RLAST  out  1  last beat to M0.
- M0_RREADY  in  1  M0 data accept.
- M1_ARADDR, M1_ARVALID, M1_ARREADY, M1_RDATA, M1_RVALID, M1_RLAST, M1_RREADY: same as M0.
- ARADDR  out  32  to slave.
- ARLEN  out  8  constant 8'd15 (16-beat burst).
- ARSIZE  out  3  constant 3'b011 (8 bytes).
- ARBURST  out  2  constant 2'b01 (INCR).
- ARVALID  out  1  to slave.
- ARREADY  in  1  from slave.
- RDATA  in  DW  from slave.
- RVALID  in  1  from slave.
- RLAST  in  1  from slave.
- RREADY  out  1  to slave.
- GRANT  out  1  current owner (0 = M0, 1 = M1); valid while BUSY is high.
- BUSY  out  1  high when state is not S_IDLE.

Behaviour:
- States: S_IDLE, S_ADDR, S_DATA. Reset puts state in S_IDLE with GRANT=0, starve counter=0; all VALID/READY outputs 0; ARADDR 0.
- S_IDLE, arbitration:
  - Neither ARVALID high: stay in S_IDLE.
  - Exactly one ARVALID high: grant that requester.
  - Both high: grant M1 if starve counter == STARVE_MAX, else grant M0.
  - On grant, register GRANT and go to S_ADDR.
- S_ADDR:
  - ARVALID=1; ARADDR = granted Mx_ARADDR, registered at grant.
  - Mx_ARREADY = ARREADY for the granted requester only; the other requester sees 0.
  - On ARREADY: go to S_DATA. ARVALID stays high until accepted and is never withdrawn.
- S_DATA:
  - RREADY = granted Mx_RREADY.
  - Granted Mx_RVALID = RVALID and Mx_RLAST = RLAST; the other requester sees 0.
  - On RVALID & RREADY & RLAST: go to S_IDLE.
- Latency:
  - Request seen in S_IDLE to ARVALID high: 1 cycle.
  - Last beat to next arbitration: 1 cycle, giving a 1-cycle S_IDLE bubble between bursts.
- Starve counter (4 bits, updated at each arbitration):
  - M0 granted while M1_ARVALID is high: +1, saturating at STARVE_MAX.
  - M1 granted, or M1_ARVALID low at arbitration: clear to 0.
- RDATA is broadcast to both requesters unconditionally; only the granted requester's RVALID qualifies it.
- Mx_ARVALID deasserting in S_ADDR is an AXI protocol violation by the requester and is not handled. The ARADDR latched at grant keeps being presented until ARREADY.
- RVALID while in S_IDLE or S_ADDR is ignored (RREADY=0); the slave must not produce this.
- ARST mid-burst: immediate return to S_IDLE with all outputs at reset values. The slave and requesters share ARST and are reset in the same cycle.
- A new request arriving during S_ADDR or S_DATA waits; there is no preemption.

Decomposition:
- Shared package disp_axi_pkg:
  - State encoding S_IDLE=2'b00, S_ADDR=2'b01, S_DATA=2'b10.
  - Constants AXI_ARLEN_16=8'd15, AXI_ARSIZE_8B=3'b011, AXI_BURST_INCR=2'b01.
- One sub-module, disp_vrdarb_sel: registered grant decision plus the starvation counter. Inputs: both ARVALIDs and the arbitrate strobe. Outputs: grant and the counter.
- The top level holds the state machine and the channel muxing.

Test Plan:
- Single M0 request, ARADDR=0x2000_0000; slave ARREADY after 2 cycles, then 16 beats → ARVALID rises 1 cycle after request; ARADDR=0x2000_0000, ARLEN=15; M0 receives exactly 16 RVALID beats with RLAST on beat 16; M1_RVALID stays 0; BUSY falls 1 cycle after the last beat.
- M0 and M1 request continuously, STARVE_MAX=4 → grant sequence M0,M0,M0,M0,M1 repeating; M1 never waits more than 4 bursts.
- M1 holds RREADY low for 3 cycles mid-burst → RREADY to slave is 0 for those cycles; no beat lost or duplicated; data order is preserved.
- M1 requests during an M0 S_DATA phase → M1 is granted exactly 1 cycle after M0's RLAST handshake; M0's burst is not truncated.
- ARST asserted for 1 cycle on beat 7 of an M1 burst → next cycle: ARVALID=0, RREADY=0, BUSY=0, starve counter=0; a fresh M0 request afterwards completes normally.
- ARREADY held low for 10 cycles in S_ADDR → ARVALID and ARADDR stay stable for all 10 cycles; Mx_ARREADY pulses for exactly 1 cycle on acceptance.
